// File: rtl/fft_input_framer.sv
// -----------------------------------------------------------------------------
// fft_input_framer
//
// Front end of the CORDIC FFT pipeline. Collects a serial stream of complex
// IEEE-754 single-precision samples into a ping-pong frame buffer of N samples.
// Each completed frame is replayed as N/2 butterfly pairs in one gapless valid
// burst. Sample bits pass through untouched; only order and rate change.
//
// Configuration macro:
//   BITREV_EN  - when defined, samples are stored at bit-reversed addresses and
//                pair k is (A, B) = (x[bitrev(2k)], x[bitrev(2k+1)]), which is
//                the DIT input order. When undefined, samples are stored in
//                natural order and pair k is (x[k], x[k+N/2]), the DIF order.
//
// Ports:
//   i_clk          clock, everything on the rising edge
//   i_reset        synchronous, active-high reset
//   i_valid_in     qualifies i_data_real / i_data_imag
//   i_data_real    input sample, real part (DW bits)
//   i_data_imag    input sample, imaginary part (DW bits)
//   o_valid_out    pair valid; high for exactly N/2 consecutive cycles per frame
//   o_frame_start  high with pair k=0 of each burst only
//   o_data_a_*     pair element A (real / imag)
//   o_data_b_*     pair element B (real / imag)
//
// Latency: last sample written at edge t -> READ at t+1 -> RAM data at t+2 ->
// o_valid_out with pair 0 at t+3.
// -----------------------------------------------------------------------------
module fft_input_framer #(
  parameter int N  = 1024,
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_valid_in,
  input  logic [DW-1:0] i_data_real,
  input  logic [DW-1:0] i_data_imag,
  output logic          o_valid_out,
  output logic          o_frame_start,
  output logic [DW-1:0] o_data_a_real,
  output logic [DW-1:0] o_data_a_imag,
  output logic [DW-1:0] o_data_b_real,
  output logic [DW-1:0] o_data_b_imag
);

  localparam int AW = $clog2(N);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  localparam logic [AW-1:0] WR_LAST = AW'(N - 1);

  // Write side
  logic [AW-1:0]   wr_cnt;
  logic [AW-1:0]   wr_addr;
  logic            wr_bank;
  logic            post;

  // Hand-off between write side and read FSM
  logic            pend;
  logic            pend_bank;

  // Read side
  logic [0:0]      state;
  logic            rd_bank;
  logic [AW-2:0]   rd_cnt;
  logic            last_pair;
  logic            start;
  logic [AW-1:0]   rd_addr_a;
  logic [AW-1:0]   rd_addr_b;

  // Both banks live in one array; the bank bit is the address MSB.
  logic [2*DW-1:0] mem [2*N];
  logic [2*DW-1:0] ram_a;
  logic [2*DW-1:0] ram_b;

  // Read pipeline flags aligned with the registered RAM output
  logic            rd_en_q;
  logic            rd_first_q;

`ifdef BITREV_EN
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  assign wr_addr   = bitrev(wr_cnt);
  // Bank holds x[bitrev(n)] at address n, so adjacent addresses form DIT pairs.
  assign rd_addr_a = {rd_cnt, 1'b0};
  assign rd_addr_b = {rd_cnt, 1'b1};
`else
  assign wr_addr   = wr_cnt;
  // DIF pairs are x[k] and x[k+N/2]: same offset, opposite halves.
  assign rd_addr_a = {1'b0, rd_cnt};
  assign rd_addr_b = {1'b1, rd_cnt};
`endif

  assign post      = i_valid_in && (wr_cnt == WR_LAST);
  assign last_pair = (rd_cnt == '1);
  // A pending frame is picked up from IDLE or right after the final pair.
  assign start     = pend && ((state == ST_IDLE) || ((state == ST_READ) && last_pair));

  // ---------------------------------------------------------------------------
  // Write counter and bank select
  // ---------------------------------------------------------------------------
  // NOTE: every clocked register uses non-blocking (<=) so all flops update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (i_valid_in) begin
      wr_cnt <= wr_cnt + 1'b1;      // wraps to 0 after sample N-1
      if (post) wr_bank <= ~wr_bank;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame RAM: one write port, two registered read ports
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; clearing it would prevent RAM
  // inference, and stale contents are never read before being rewritten.
  always_ff @(posedge i_clk) begin
    if (i_valid_in && !i_reset) mem[{wr_bank, wr_addr}] <= {i_data_real, i_data_imag};
    ram_a <= mem[{rd_bank, rd_addr_a}];
    ram_b <= mem[{rd_bank, rd_addr_b}];
  end

  // ---------------------------------------------------------------------------
  // Read FSM and the pending-frame flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pend      <= 1'b0;
      pend_bank <= 1'b0;
      state     <= ST_IDLE;
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
    end else begin
      // A fresh post wins over a same-cycle pickup so the new frame is kept.
      if (post) begin
        pend      <= 1'b1;
        pend_bank <= wr_bank;
      end else if (start) begin
        pend <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (pend) begin
            state   <= ST_READ;
            rd_bank <= pend_bank;
            rd_cnt  <= '0;
          end
        end
        ST_READ: begin
          rd_cnt <= rd_cnt + 1'b1;     // wraps to 0 after the final pair
          if (last_pair) begin
            if (pend) rd_bank <= pend_bank;  // adjacent burst, stay in READ
            else      state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: one register after the RAM read
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rd_en_q       <= 1'b0;
      rd_first_q    <= 1'b0;
      o_valid_out   <= 1'b0;
      o_frame_start <= 1'b0;
      o_data_a_real <= '0;
      o_data_a_imag <= '0;
      o_data_b_real <= '0;
      o_data_b_imag <= '0;
    end else begin
      rd_en_q       <= (state == ST_READ);
      rd_first_q    <= (state == ST_READ) && (rd_cnt == '0);
      o_valid_out   <= rd_en_q;
      o_frame_start <= rd_first_q;
      // Data holds its last value between bursts.
      if (rd_en_q) begin
        {o_data_a_real, o_data_a_imag} <= ram_a;
        {o_data_b_real, o_data_b_imag} <= ram_b;
      end
    end
  end

endmodule
